// File: rtl/fpu_arbiter.sv
// Two-requester round-robin front end for a fixed-latency pipelined FPU.
// Results are matched to requesters through a tag pipeline that mirrors the FPU latency.
module fpu_arbiter #(
    parameter int unsigned FPU_LAT = 4,
    parameter int unsigned MAX_OUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_A,
    input  logic [31:0] req0_B,
    input  logic [1:0]  req0_sel,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_A,
    input  logic [31:0] req1_B,
    input  logic [1:0]  req1_sel,
    output logic        fpu_start,
    output logic [31:0] fpu_A,
    output logic [31:0] fpu_B,
    output logic [1:0]  fpu_sel,
    input  logic [31:0] fpu_Y,
    input  logic        fpu_overflow,
    input  logic        fpu_error,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_Y,
    output logic        rsp_overflow,
    output logic        rsp_error,
    output logic [3:0]  inflight,
    output logic        busy
);

    logic               last;
    logic               fpu_id;
    logic [FPU_LAT-1:0] tag_vld;
    logic [FPU_LAT-1:0] tag_id;
    logic               retire;
    logic               room;
    logic               accept;
    logic               grant_id;

    // A retiring response frees its slot in the same cycle, so a full
    // window can still take a new operation while one drains.
    assign retire     = tag_vld[FPU_LAT-1];
    assign room       = !reset && (inflight != 4'(MAX_OUT) || retire);
    assign req0_ready = room && req0_valid && (!req1_valid || last);
    assign req1_ready = room && req1_valid && (!req0_valid || !last);
    assign accept     = req0_ready || req1_ready;
    assign grant_id   = req1_ready;
    assign busy       = (inflight != 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            last         <= 1'b1;
            fpu_id       <= 1'b0;
            fpu_start    <= 1'b0;
            fpu_A        <= '0;
            fpu_B        <= '0;
            fpu_sel      <= '0;
            tag_vld      <= '0;
            tag_id       <= '0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp_Y        <= '0;
            rsp_overflow <= 1'b0;
            rsp_error    <= 1'b0;
            inflight     <= '0;
        end else begin
            fpu_start <= accept;
            if (accept) begin
                fpu_A   <= grant_id ? req1_A   : req0_A;
                fpu_B   <= grant_id ? req1_B   : req0_B;
                fpu_sel <= grant_id ? req1_sel : req0_sel;
                fpu_id  <= grant_id;
                last    <= grant_id;
            end
            // Tag stage 0 captures the issue strobe the FPU samples on this edge.
            tag_vld[0] <= fpu_start;
            tag_id[0]  <= fpu_id;
            for (int i = 1; i < int'(FPU_LAT); i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
            rsp0_valid <= retire && !tag_id[FPU_LAT-1];
            rsp1_valid <= retire &&  tag_id[FPU_LAT-1];
            if (retire) begin
                rsp_Y        <= fpu_Y;
                rsp_overflow <= fpu_overflow;
                rsp_error    <= fpu_error;
            end
            inflight <= inflight + {3'd0, accept} - {3'd0, retire};
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: scoreboarded traffic on a default instance plus a
// credit-limit run on a long-latency instance.
module tb_fpu_arbiter;
    localparam int LAT  = 4;
    localparam int MO   = 8;
    localparam int LATC = 12;
    localparam int MOC  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Stand-in FPU arithmetic: 1.0+2.0 is exact, everything else is a mixing function.
    function automatic logic [33:0] fpu_fn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
        if (a == 32'h3F800000 && b == 32'h40000000 && s == 2'b00)
            return {2'b00, 32'h40400000};
        return {a[0] ^ b[1], b[0] | s[0], (a ^ {b[15:0], b[31:16]}) + {30'd0, s}};
    endfunction

    // ---------------- instance A (default parameters)
    logic        reset;
    logic        v0, v1, r0, r1;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  s0, s1;
    logic        fpu_start;
    logic [31:0] fpu_A, fpu_B, fpu_Y;
    logic [1:0]  fpu_sel;
    logic        fpu_ov, fpu_er;
    logic        rsp0, rsp1;
    logic [31:0] rsp_Y;
    logic        rsp_ov, rsp_er;
    logic [3:0]  inflight;
    logic        busy;

    fpu_arbiter #(.FPU_LAT(LAT), .MAX_OUT(MO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(v0), .req0_ready(r0), .req0_A(a0), .req0_B(b0), .req0_sel(s0),
        .req1_valid(v1), .req1_ready(r1), .req1_A(a1), .req1_B(b1), .req1_sel(s1),
        .fpu_start(fpu_start), .fpu_A(fpu_A), .fpu_B(fpu_B), .fpu_sel(fpu_sel),
        .fpu_Y(fpu_Y), .fpu_overflow(fpu_ov), .fpu_error(fpu_er),
        .rsp0_valid(rsp0), .rsp1_valid(rsp1), .rsp_Y(rsp_Y),
        .rsp_overflow(rsp_ov), .rsp_error(rsp_er),
        .inflight(inflight), .busy(busy)
    );

    logic [33:0] fa_pipe [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) fa_pipe[i] <= fa_pipe[i-1];
        fa_pipe[0] <= fpu_start ? fpu_fn(fpu_A, fpu_B, fpu_sel) : {2'($urandom), 32'($urandom)};
    end
    assign fpu_Y  = fa_pipe[LAT-1][31:0];
    assign fpu_er = fa_pipe[LAT-1][32];
    assign fpu_ov = fa_pipe[LAT-1][33];

    // ---------------- instance C (long latency, credit limited)
    logic        c_rst, c_v0, c_r0, c_r1, c_start, c_rsp0, c_rsp1, c_ov, c_er, c_rov, c_rer, c_busy;
    logic [31:0] c_A, c_B, c_Y, c_rY;
    logic [1:0]  c_sel;
    logic [3:0]  c_inf;

    fpu_arbiter #(.FPU_LAT(LATC), .MAX_OUT(MOC)) dut_c (
        .clk(clk), .reset(c_rst),
        .req0_valid(c_v0), .req0_ready(c_r0), .req0_A(32'h3F800000), .req0_B(32'h40000000), .req0_sel(2'b00),
        .req1_valid(1'b0), .req1_ready(c_r1), .req1_A(32'h0), .req1_B(32'h0), .req1_sel(2'b00),
        .fpu_start(c_start), .fpu_A(c_A), .fpu_B(c_B), .fpu_sel(c_sel),
        .fpu_Y(c_Y), .fpu_overflow(c_ov), .fpu_error(c_er),
        .rsp0_valid(c_rsp0), .rsp1_valid(c_rsp1), .rsp_Y(c_rY),
        .rsp_overflow(c_rov), .rsp_error(c_rer),
        .inflight(c_inf), .busy(c_busy)
    );

    logic [33:0] fc_pipe [LATC];
    always @(posedge clk) begin
        for (int i = LATC - 1; i > 0; i--) fc_pipe[i] <= fc_pipe[i-1];
        fc_pipe[0] <= c_start ? fpu_fn(c_A, c_B, c_sel) : {2'($urandom), 32'($urandom)};
    end
    assign c_Y  = fc_pipe[LATC-1][31:0];
    assign c_er = fc_pipe[LATC-1][32];
    assign c_ov = fc_pipe[LATC-1][33];

    // ---------------- scoreboard / monitor for instance A
    typedef struct {
        logic        id;
        logic [31:0] y;
        logic        ov;
        logic        er;
        int          t;
    } exp_t;

    exp_t        sbq[$];
    bit          glog[$];
    int          cyc = 0;
    bit          mon_en = 0;
    bit          log_en = 0;
    bit          last_g = 1;
    bit          exp_start = 0;
    logic [31:0] exp_A = '0, exp_B = '0;
    logic [1:0]  exp_sel = '0;
    logic [31:0] hold_Y = '0;
    logic        hold_ov = 0, hold_er = 0;
    exp_t        e;
    bit          ret, room, e0, e1;
    logic [33:0] res;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("fpu_start", fpu_start, exp_start);
            if (exp_start) begin
                chk("fpu_A", fpu_A, exp_A);
                chk("fpu_B", fpu_B, exp_B);
                chk("fpu_sel", fpu_sel, exp_sel);
            end
            if (rsp0 || rsp1) begin
                chk("rsp_onehot", rsp0 && rsp1, 0);
                if (sbq.size() == 0) chk("rsp_spurious", 1, 0);
                else begin
                    e = sbq.pop_front();
                    chk("rsp_id", rsp1, e.id);
                    chk("rsp_Y", rsp_Y, e.y);
                    chk("rsp_ov", rsp_ov, e.ov);
                    chk("rsp_err", rsp_er, e.er);
                    chk("rsp_lat", cyc - e.t, LAT + 1);
                    hold_Y = e.y; hold_ov = e.ov; hold_er = e.er;
                end
            end else begin
                chk("hold_Y", rsp_Y, hold_Y);
                chk("hold_ov", rsp_ov, hold_ov);
                chk("hold_err", rsp_er, hold_er);
            end
            chk("inflight", inflight, sbq.size());
            chk("busy", busy, sbq.size() != 0);

            ret  = sbq.size() != 0 && sbq[0].t + LAT + 1 == cyc + 1;
            room = sbq.size() < MO || ret;
            e0   = !reset && v0 && room && (!v1 || last_g);
            e1   = !reset && v1 && room && (!v0 || !last_g);
            chk("ready0", r0, e0);
            chk("ready1", r1, e1);

            exp_start = 0;
            if (reset) begin
                sbq.delete();
                hold_Y = '0; hold_ov = 0; hold_er = 0;
                last_g = 1;
            end else if (e0 || e1) begin
                exp_A   = e1 ? a1 : a0;
                exp_B   = e1 ? b1 : b0;
                exp_sel = e1 ? s1 : s0;
                res     = fpu_fn(exp_A, exp_B, exp_sel);
                sbq.push_back('{id: e1, y: res[31:0], ov: res[33], er: res[32], t: cyc + 1});
                if (log_en) glog.push_back(e1);
                last_g    = e1;
                exp_start = 1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rnd_ops();
        a0 = $urandom; b0 = $urandom; s0 = 2'($urandom);
        a1 = $urandom; b1 = $urandom; s1 = 2'($urandom);
    endtask

    initial begin
        reset = 1; c_rst = 1; c_v0 = 0;
        v0 = 1; v1 = 1;
        rnd_ops();
        step(1);
        mon_en = 1;
        step(2);

        // Contention straight out of reset.
        reset = 0; log_en = 1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            rnd_ops();
        end
        log_en = 0; v0 = 0; v1 = 0;
        chk("grant_count", glog.size(), 6);
        for (int i = 0; i < 6 && i < glog.size(); i++) chk("grant_order", glog[i], i % 2);
        step(10);

        // Single op from req0.
        v0 = 1; a0 = 32'h3F800000; b0 = 32'h40000000; s0 = 2'b00;
        step(1);
        v0 = 0;
        step(10);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            v0 = 1'($urandom); v1 = 1'($urandom);
            rnd_ops();
            step(1);
        end
        v0 = 0; v1 = 0;
        step(10);

        // Idle: outputs must hold.
        step(20);

        // Reset while three ops are in flight.
        v0 = 1;
        for (int i = 0; i < 3; i++) begin
            rnd_ops();
            step(1);
        end
        v0 = 0; reset = 1;
        step(1);
        reset = 0;
        step(15);
        v1 = 1; rnd_ops();
        step(1);
        v1 = 0;
        step(10);
        chk("sb_empty", sbq.size(), 0);

        // Credit limit on the long-latency instance.
        c_rst = 0; c_v0 = 1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            chk("c_ready0", c_r0, (k < 8 || k >= 13));
            chk("c_ready1", c_r1, 0);
            chk("c_inflight", c_inf, (k < 8) ? k : 8);
            chk("c_rsp0", c_rsp0, k >= 14);
            if (k == 14) chk("c_rsp_Y", c_rY, 32'h40400000);
        end
        c_v0 = 0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
